// File: rtl/bcd_mod_counter.sv
// Modulo-N BCD counter with synchronous validated load and a one-cycle wrap pulse for cascading.
// Define COUNTER_DOWN_EN to add the up_dn port and BCD down counting with borrow on wrap.
module bcd_mod_counter #(
  parameter int DIGITS  = 2,
  parameter int MODULUS = 60
) (
  input  logic                clk100hz,
  input  logic                rst,
  input  logic                carry_in,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
`ifdef COUNTER_DOWN_EN
  input  logic                up_dn,
`endif
  output logic [4*DIGITS-1:0] cnt,
  output logic                carry_out,
  output logic                load_err
);

  localparam int          DATA_W = 4 * DIGITS;
  localparam int unsigned MOD_U  = MODULUS;

  function automatic logic [DATA_W-1:0] bin_to_bcd(input int unsigned v);
    logic [DATA_W-1:0] r;
    int unsigned       rem;
    r   = '0;
    rem = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(rem % 10);
      rem         = rem / 10;
    end
    return r;
  endfunction

  localparam logic [DATA_W-1:0] MAX_BCD = bin_to_bcd(MOD_U - 1);

  // A load is accepted only if every nibble is a decimal digit and the value is in range.
  function automatic logic load_ok(input logic [DATA_W-1:0] v);
    int unsigned acc;
    logic        ok;
    acc = 0;
    ok  = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
      acc = acc * 10 + {28'd0, v[4*i +: 4]};
    end
    return ok && (acc < MOD_U);
  endfunction

  function automatic logic [DATA_W-1:0] bcd_inc(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    logic              c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c           = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] bcd_dec(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    logic              b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (b) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          b           = 1'b0;
        end
      end
    end
    return r;
  endfunction

  logic              count_dn;
  logic [DATA_W-1:0] cnt_nxt;
  logic              carry_nxt;
  logic              err_nxt;

`ifdef COUNTER_DOWN_EN
  assign count_dn = ~up_dn;
`else
  assign count_dn = 1'b0;
`endif

  always_comb begin
    cnt_nxt   = cnt;
    carry_nxt = 1'b0;
    err_nxt   = 1'b0;
    if (load) begin
      if (load_ok(load_val)) cnt_nxt = load_val;
      else                   err_nxt = 1'b1;
    end else if (carry_in) begin
      if (count_dn) begin
        if (cnt == '0) begin
          cnt_nxt   = MAX_BCD;
          carry_nxt = 1'b1;
        end else begin
          cnt_nxt = bcd_dec(cnt);
        end
      end else begin
        if (cnt == MAX_BCD) begin
          cnt_nxt   = '0;
          carry_nxt = 1'b1;
        end else begin
          cnt_nxt = bcd_inc(cnt);
        end
      end
    end
  end

  always_ff @(posedge clk100hz or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      carry_out <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      carry_out <= carry_nxt;
      load_err  <= err_nxt;
    end
  end

endmodule

// File: doc/bcd_mod_counter.md
BCD_MOD_COUNTER -- requirements
Module: bcd_mod_counter

Interface
REQ-001 Parameter DIGITS, default 2: number of BCD digits; legal range 1..4.
REQ-002 Parameter MODULUS, default 60: count modulus; legal range 2..10^DIGITS.
REQ-003 Port clk100hz, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 Port carry_in, input, 1 bit: count enable, sampled each rising edge.
REQ-006 Port load, input, 1 bit: synchronous load request (time-set).
REQ-007 Port load_val, input, 4*DIGITS bits: BCD value to load; digit 0 is in bits [3:0].
REQ-008 Port up_dn, input, 1 bit, present only with COUNTER_DOWN_EN: 1 = count up, 0 = count down.
REQ-009 Port cnt, output, 4*DIGITS bits: registered BCD count; digit 0 is in bits [3:0].
REQ-010 Port carry_out, output, 1 bit: registered one-cycle wrap (carry/borrow) pulse.
REQ-011 Port load_err, output, 1 bit: registered one-cycle pulse flagging a rejected load.

Function
REQ-012 cnt shall always hold a valid BCD value in 0..MODULUS-1.
REQ-013 Priority per edge shall be load > carry_in > hold.
REQ-014 When load=1, cnt shall take load_val at that edge if every nibble is <=9 and the value is <MODULUS; carry_out=0 on that edge.
REQ-015 An invalid load_val (any nibble >9, or value >=MODULUS) shall leave cnt unchanged and pulse load_err=1 for exactly one cycle.
REQ-016 When load=1, carry_in shall be ignored for that edge, whether or not the load is valid.
REQ-017 When load=0 and carry_in=1 (up mode), cnt shall increment by 1 in BCD, with per-digit 9->0 ripple within the same edge (no multi-cycle latency).
REQ-018 Up wrap: when cnt==MODULUS-1 and carry_in=1, cnt shall become 0 and carry_out shall be 1 for that single following cycle.
REQ-019 carry_out shall be 0 on every edge without a wrap, including edges where carry_in=0; it shall never hold high for two consecutive cycles unless wraps occur on consecutive edges.
REQ-020 When carry_in=0 and load=0, cnt shall hold and carry_out and load_err shall be 0.
REQ-021 Cascading shall be supported: carry_out of one instance drives carry_in of the next, giving exactly one higher-stage step per lower-stage wrap.
REQ-022 MODULUS=10^DIGITS shall wrap at all-nines; MODULUS=2 with DIGITS=1 shall toggle 0/1.

Reset
REQ-023 While rst=1, cnt=0, carry_out=0 and load_err=0, immediately, without waiting for a clock edge.
REQ-024 Reset asserted mid-count or mid-load shall abort the operation; the first edge after deassertion shall be processed normally from cnt=0.

Configuration
REQ-025 Macro COUNTER_DOWN_EN defined: the up_dn port shall exist; up_dn=1 shall behave per REQ-017/018; up_dn=0 with carry_in=1 shall decrement in BCD (per-digit 0->9 borrow ripple).
REQ-026 With COUNTER_DOWN_EN defined, a down count from cnt==0 shall load MODULUS-1 and pulse carry_out (borrow) for one cycle; up_dn shall be sampled on the same edge as carry_in.
REQ-027 Macro COUNTER_DOWN_EN undefined: there shall be no up_dn port, and the block shall count up only per REQ-017/018.

Verification
REQ-028 DIGITS=2, MODULUS=60, carry_in=1 continuous from reset -> cnt steps 0x00..0x59, then 0x00; carry_out=1 only in the cycle cnt returns to 0x00 (every 60 cycles).
REQ-029 cnt=0x09, carry_in=1 -> cnt=0x10 next cycle, carry_out=0; cnt=0x23, carry_in=0 for 5 cycles -> cnt stays 0x23.
REQ-030 load=1, load_val=0x45 with carry_in=1 -> cnt=0x45, no increment, load_err=0; load_val=0x60 or 0x3A -> cnt unchanged, load_err one-cycle pulse.
REQ-031 Two instances cascaded (MODULUS 60 then 24), carry_in=1 for 1440 cycles -> upper stage returns to 0x00; upper carry_out pulses once.
REQ-032 rst pulsed between clock edges while cnt=0x37 -> cnt=0x00 before the next edge; counting resumes 0x01 on the first enabled edge after release.
REQ-033 COUNTER_DOWN_EN, cnt=0x10, up_dn=0, carry_in=1 -> 0x09; from 0x00 -> 0x59 with carry_out=1 for one cycle.
